// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, defaults and helpers for the FIFO arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 8;

    // Returns at least 1 so that derived vector widths never collapse to zero.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector, upward search from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic             any
);

    always_comb begin
        logic w_found;
        int   w_idx;
        win     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                win[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Burst-granting round-robin arbiter for the FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                       W_CLK,
    input  logic                       W_RST,
    input  logic [NREQ-1:0]            REQ_VALID,
    input  logic [NREQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NREQ-1:0]            REQ_LAST,
    output logic [NREQ-1:0]            REQ_READY,
    input  logic                       FULL,
    output logic                       W_INC,
    output logic [DATA_WIDTH-1:0]      W_DATA,
    output logic [NREQ-1:0]            GNT,
    output logic                       BUSY
);

    localparam int PTR_W = clog2_min1(NREQ);
    localparam int CNT_W = clog2_min1(MAX_BURST);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(NREQ - 1);

    arb_state_t        state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [NREQ-1:0]       w_win;
    logic                  w_any;
    logic [PTR_W-1:0]      w_gidx;
    logic [PTR_W-1:0]      w_ptr_d;
    logic [DATA_WIDTH-1:0] w_data_sel;
    logic                  w_in_burst;
    logic                  w_beat;
    logic                  w_release;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (REQ_VALID),
        .ptr (ptr_q),
        .win (w_win),
        .any (w_any)
    );

    always_comb begin
        w_gidx     = '0;
        w_data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                w_gidx     = PTR_W'(i);
                w_data_sel = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_d    = (w_gidx == c_ptr_last) ? '0 : w_gidx + 1'b1;
    assign w_in_burst = (state_q == ST_BURST);
    assign w_beat     = w_in_burst && (|(REQ_VALID & gnt_q)) && !FULL;
    // A last-flagged beat that also hits the burst limit is still one release.
    assign w_release  = w_beat && ((|(REQ_LAST & gnt_q)) || (cnt_q == c_cnt_last));

    always_ff @(posedge W_CLK) begin
        if (W_RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        gnt_q   <= w_win;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_release) begin
                        gnt_q   <= '0;
                        ptr_q   <= w_ptr_d;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (w_beat) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign REQ_READY = (w_in_burst && !FULL) ? gnt_q : '0;
    assign W_INC     = w_beat;
    assign W_DATA    = w_beat ? w_data_sel : '0;
    assign GNT       = gnt_q;
    assign BUSY      = w_in_burst;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scenario bench for fifo_wr_arbiter with a write-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 8;

    logic              W_CLK;
    logic              W_RST;
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ*DW-1:0] REQ_DATA;
    logic [NREQ-1:0]   REQ_LAST;
    logic [NREQ-1:0]   REQ_READY;
    logic              FULL;
    logic              W_INC;
    logic [DW-1:0]     W_DATA;
    logic [NREQ-1:0]   GNT;
    logic              BUSY;

    fifo_wr_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .W_CLK     (W_CLK),
        .W_RST     (W_RST),
        .REQ_VALID (REQ_VALID),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .REQ_READY (REQ_READY),
        .FULL      (FULL),
        .W_INC     (W_INC),
        .W_DATA    (W_DATA),
        .GNT       (GNT),
        .BUSY      (BUSY)
    );

    initial W_CLK = 1'b0;
    always #5 W_CLK = ~W_CLK;

    int errors = 0;
    int checks = 0;

    // Per-requester beat sources: {last, data}
    logic [DW:0]     src_mem [NREQ][64];
    int              src_wr  [NREQ];
    int              src_rd  [NREQ];
    logic [NREQ-1:0] mute;
    logic [DW-1:0]   sb [$];

    logic [NREQ-1:0] s_gnt;
    logic [NREQ-1:0] s_ready;
    logic            s_busy;
    logic            s_inc;
    logic [DW-1:0]   s_wdata;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                REQ_VALID[i]           = !mute[i];
                REQ_DATA[i*DW +: DW]   = src_mem[i][src_rd[i]][DW-1:0];
                REQ_LAST[i]            = src_mem[i][src_rd[i]][DW];
            end else begin
                REQ_VALID[i]           = 1'b0;
                REQ_DATA[i*DW +: DW]   = '0;
                REQ_LAST[i]            = 1'b0;
            end
        end
    endtask

    task automatic push_beat(input int r, input logic [DW-1:0] d, input logic last);
        src_mem[r][src_wr[r]] = {last, d};
        src_wr[r]++;
    endtask

    // One clock: sample at negedge, score W_INC, advance sources after the edge.
    task automatic cycle();
        logic [NREQ-1:0] hs;
        logic [DW-1:0]   exp_d;
        @(negedge W_CLK);
        s_gnt   = GNT;
        s_ready = REQ_READY;
        s_busy  = BUSY;
        s_inc   = W_INC;
        s_wdata = W_DATA;
        hs      = W_RST ? '0 : (REQ_VALID & REQ_READY);
        checks++;
        if (W_INC && !W_RST) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_write: W_INC with W_DATA=%0h, required no write", W_DATA);
            end else begin
                exp_d = sb.pop_front();
                if (W_DATA !== exp_d) begin
                    errors++;
                    $display("FAIL sb_data: W_DATA=%0h, required %0h", W_DATA, exp_d);
                end
            end
        end else if (W_DATA !== '0) begin
            errors++;
            $display("FAIL wdata_idle: W_DATA=%0h with W_INC=%0b, required 0", W_DATA, W_INC);
        end
        @(posedge W_CLK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) src_rd[i]++;
        end
        drive();
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((sb.size() != 0 || s_busy) && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        if (sb.size() != 0 || s_busy) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats outstanding busy=%0b, required 0", sb.size(), s_busy);
        end
    endtask

    task automatic do_reset();
        W_RST = 1'b1;
        FULL  = 1'b0;
        mute  = '0;
        sb.delete();
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        drive();
        cycle();
        cycle();
        W_RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle();
        if (s_gnt !== '0)   begin errors++; $display("FAIL reset_gnt: got %b, required 0", s_gnt); end
        if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", s_busy); end
        if (s_inc !== 1'b0)  begin errors++; $display("FAIL reset_winc: got %b, required 0", s_inc); end
        if (s_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 0", s_ready); end
        checks += 4;
    endtask

    task automatic test_single_burst();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_beat(2, 8'(8'hA0 + k), k == 2);
            sb.push_back(8'(8'hA0 + k));
        end
        drive();
        cycle();
        checks++;
        if (s_busy !== 1'b0 || s_gnt !== '0) begin
            errors++;
            $display("FAIL arb_latency: busy=%b gnt=%b, required 0/0", s_busy, s_gnt);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (s_gnt !== 4'b0100 || s_inc !== 1'b1) begin
                errors++;
                $display("FAIL burst_beat%0d: gnt=%b winc=%b, required 0100/1", k, s_gnt, s_inc);
            end
        end
        cycle();
        checks++;
        if (s_gnt !== '0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_release: gnt=%b busy=%b, required 0/0", s_gnt, s_busy);
        end
        // Pointer now sits at 3, so requester 3 must beat requester 1.
        push_beat(1, 8'h11, 1'b1);
        push_beat(3, 8'h33, 1'b1);
        sb.push_back(8'h33);
        sb.push_back(8'h11);
        drive();
        cycle();
        drain(20);
    endtask

    task automatic test_back_to_back();
        int ord;
        int last_n;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_beat(i, 8'(i * 16 + r), 1'b1);
                sb.push_back(8'(i * 16 + r));
            end
        end
        drive();
        ord    = 0;
        last_n = 0;
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            cycle();
            if (s_inc) begin
                checks++;
                if (s_gnt !== 4'(1 << (ord % NREQ)) || (ord > 0 && n - last_n != 2)) begin
                    errors++;
                    $display("FAIL rr_order%0d: gnt=%b gap=%0d, required %b gap 2",
                             ord, s_gnt, n - last_n, 4'(1 << (ord % NREQ)));
                end
                ord++;
                last_n = n;
            end
        end
        checks++;
        if (ord != 2 * NREQ) begin
            errors++;
            $display("FAIL rr_count: %0d grants, required %0d", ord, 2 * NREQ);
        end
        drain(10);
    endtask

    task automatic test_max_burst();
        int  cnt1;
        logic released;
        logic seen_next;
        do_reset();
        for (int k = 0; k < 10; k++) push_beat(1, 8'(8'h40 + k), k == 9);
        push_beat(2, 8'h77, 1'b1);
        for (int k = 0; k < MB; k++) sb.push_back(8'(8'h40 + k));
        sb.push_back(8'h77);
        sb.push_back(8'h48);
        sb.push_back(8'h49);
        drive();
        cnt1      = 0;
        released  = 1'b0;
        seen_next = 1'b0;
        for (int n = 0; n < 60 && (sb.size() != 0 || s_busy); n++) begin
            cycle();
            if (!released && s_inc && s_gnt == 4'b0010) cnt1++;
            if (!released && cnt1 > 0 && s_gnt != 4'b0010) begin
                released = 1'b1;
                checks++;
                if (cnt1 != MB) begin
                    errors++;
                    $display("FAIL max_burst_len: %0d beats, required %0d", cnt1, MB);
                end
            end else if (released && !seen_next && s_gnt != '0) begin
                seen_next = 1'b1;
                checks++;
                if (s_gnt !== 4'b0100) begin
                    errors++;
                    $display("FAIL max_burst_next: gnt=%b, required 0100", s_gnt);
                end
            end
        end
        drain(10);
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push_beat(0, 8'(8'hC0 + k), k == 4);
            sb.push_back(8'(8'hC0 + k));
        end
        drive();
        cycle();
        cycle();
        cycle();
        FULL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (s_inc !== 1'b0 || s_ready !== '0 || s_gnt !== 4'b0001 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL full_stall%0d: winc=%b ready=%b gnt=%b, required 0/0000/0001", k, s_inc, s_ready, s_gnt);
            end
        end
        FULL = 1'b0;
        cycle();
        checks++;
        if (s_inc !== 1'b1 || s_ready !== 4'b0001) begin
            errors++;
            $display("FAIL full_resume: winc=%b ready=%b, required 1/0001", s_inc, s_ready);
        end
        drain(20);
    endtask

    task automatic test_valid_drop();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_beat(0, 8'(8'hD0 + k), k == 3);
            sb.push_back(8'(8'hD0 + k));
        end
        push_beat(3, 8'hE3, 1'b1);
        sb.push_back(8'hE3);
        drive();
        cycle();
        cycle();
        cycle();
        mute[0] = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (s_inc !== 1'b0 || s_gnt !== 4'b0001 || s_ready !== 4'b0001) begin
                errors++;
                $display("FAIL bubble%0d: winc=%b gnt=%b ready=%b, required 0/0001/0001", k, s_inc, s_gnt, s_ready);
            end
        end
        mute[0] = 1'b0;
        drive();
        drain(20);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 6; k++) push_beat(1, 8'(8'h50 + k), k == 5);
        for (int k = 0; k < 4; k++) sb.push_back(8'(8'h50 + k));
        sb.push_back(8'h0F);
        sb.push_back(8'h54);
        sb.push_back(8'h55);
        drive();
        for (int k = 0; k < 5; k++) cycle();
        W_RST = 1'b1;
        FULL  = 1'b1;
        push_beat(0, 8'h0F, 1'b1);
        drive();
        cycle();
        W_RST = 1'b0;
        FULL  = 1'b0;
        cycle();
        checks++;
        if (s_gnt !== '0 || s_busy !== 1'b0 || s_inc !== 1'b0 || s_ready !== '0 || s_wdata !== '0) begin
            errors++;
            $display("FAIL rst_mid: gnt=%b busy=%b winc=%b ready=%b wdata=%0h, required all 0",
                     s_gnt, s_busy, s_inc, s_ready, s_wdata);
        end
        cycle();
        checks++;
        if (s_gnt !== 4'b0001 || s_inc !== 1'b1) begin
            errors++;
            $display("FAIL rst_ptr: gnt=%b winc=%b, required 0001/1", s_gnt, s_inc);
        end
        drain(20);
    endtask

    initial begin
        W_RST     = 1'b1;
        FULL      = 1'b0;
        mute      = '0;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;
        s_gnt     = '0;
        s_ready   = '0;
        s_busy    = 1'b0;
        s_inc     = 1'b0;
        s_wdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_max_burst();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port among `NREQ` requesters, granting one requester at a time for a burst of beats. It drives `W_INC`/`W_DATA` into the FIFO write stage and honours its `FULL` flag. It lives entirely in the write clock domain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 8: maximum beats per grant; the grant is forcibly released at this count.

Ports:
- `W_CLK`  in  1  write-domain clock; all logic on its rising edge.
- `W_RST`  in  1  reset, **synchronous, active-high**.
- `REQ_VALID`  in  NREQ  per-requester beat valid.
- `REQ_DATA`  in  NREQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `REQ_LAST`  in  NREQ  marks the final beat of a requester's burst.
- `REQ_READY`  out  NREQ  per-requester beat accept.
- `FULL`  in  1  FIFO full flag from the write stage.
- `W_INC`  out  1  FIFO write enable.
- `W_DATA`  out  DATA_WIDTH  FIFO write data.
- `GNT`  out  NREQ  one-hot current grant (registered).
- `BUSY`  out  1  high while in the BURST state.

## Operation
- FSM has two states.
  - **IDLE**: `GNT`=0. If any `REQ_VALID` is set, select a winner by round-robin, searching upward (with wrap) from priority pointer `ptr`. Register `GNT`=onehot(winner), clear `beat_cnt`, and go to BURST. If no request is present, stay in IDLE.
  - **BURST**: the granted index is g.
    - `REQ_READY[g]` = !`FULL`. All other `REQ_READY` bits are 0.
    - A beat occurs when `REQ_VALID[g]` && !`FULL`. On a beat: `W_INC`=1, `W_DATA`=`REQ_DATA[g]`, and `beat_cnt`++.
    - The grant is released on a beat where `REQ_LAST[g]`=1 or `beat_cnt`==`MAX_BURST`-1. On release: `GNT`←0, `ptr`←(g+1) mod `NREQ`, next state IDLE.
- Outside a beat, `W_INC`=0 and `W_DATA`=0.
- `beat_cnt` width is clog2(`MAX_BURST`). It never wraps, because release occurs at `MAX_BURST`-1.
- `BUSY` = (state==BURST).

Boundary conditions:
- `FULL` during BURST: stall. No beat, `beat_cnt` holds, and the grant is held indefinitely.
- Granted requester drops `REQ_VALID` mid-burst: the grant is held (bubble) and no `W_INC` is issued. There is no timeout other than `MAX_BURST` beats.
- Non-granted requesters may toggle `REQ_VALID` freely; this has no effect until the next IDLE cycle.
- `REQ_LAST` on a non-beat cycle (`FULL` high or valid low) is ignored.
- `REQ_LAST` on the `MAX_BURST`-th beat gives a single release, not a double one.
- Reset mid-burst: the next cycle is IDLE with `GNT`=0, `ptr`=0 and `beat_cnt`=0. The partial burst is abandoned.

## Timing
- Reset values: state=IDLE, `GNT`=0, `ptr`=0, `beat_cnt`=0, `BUSY`=0, `W_INC`=0, `REQ_READY`=0, `W_DATA`=0.
- Arbitration latency: `REQ_VALID` seen in IDLE at edge n makes `GNT`/`BUSY` valid after edge n+1. The first beat can occur in the cycle following edge n+1.
- `W_INC`, `W_DATA` and `REQ_READY` are combinational from registered state, `REQ_VALID[g]` and `FULL`. The FIFO write stage samples them on the same edge that completes the handshake.
- Exactly one IDLE cycle separates consecutive grants, so steady-state throughput is `MAX_BURST`/(`MAX_BURST`+1) beats per cycle under continuous requests.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,`NREQ`-1,0.

## Structure
- Shared package `fifo_arb_pkg`:
  - state enum (IDLE, BURST);
  - default `NREQ`, `DATA_WIDTH` and `MAX_BURST` constants;
  - a clog2 helper.
- Sub-module `rr_pick`: a combinational round-robin selector. It takes `req[NREQ]` and `ptr`, and returns one-hot `win` and `any`. It is reusable for a read-side scheduler.
- The top level contains the FSM, `ptr`, `beat_cnt`, the `GNT` register and the output muxing.

## Test plan
- Reset, then `REQ_VALID`=4'b0100 with a 3-beat burst (last on beat 3), `FULL`=0 -> `GNT`=4'b0100 one cycle later, exactly 3 `W_INC` pulses with matching data, then `GNT`=0 and `ptr`=3.
- All 4 requesters issue continuous 1-beat bursts -> grant order 0,1,2,3,0, with each grant separated by one IDLE cycle.
- Requester 1 streams without `REQ_LAST`, `MAX_BURST`=8 -> forced release after exactly 8 `W_INC`s, and requester 2 (also valid) is granted next.
- `FULL` asserted for 5 cycles mid-burst after beat 2 -> no `W_INC` and `REQ_READY`=0 during the stall, burst resumes at beat 3, and total beats are unchanged.
- Granted requester drops `REQ_VALID` for 3 cycles -> grant held, no `W_INC`, and other requesters stay unready.
- `W_RST` asserted mid-burst (beat 4 of 6) -> next cycle all outputs at reset values, and the next grant goes to requester 0 if it is valid.
